// File: rtl/param_bit_rev_unit.sv
// ---------------------------------------------------------------------------
// param_bit_rev_unit
//
// Bit-reversal helper for datapath formatting, such as LSB-first serial
// framing and FFT index reordering. It provides two paths.
//
//   Combinational path:
//      out is always the full bit reversal of in_. It has zero latency and
//      does not depend on clk, reset, in_val or rev_mode.
//
//   Registered path (one cycle of latency):
//      When in_val is high, a rising edge captures in_ through the transform
//      selected by rev_mode.
//         00 = full reverse
//         01 = pass-through
//         10 = nibble-reverse (each 4-bit group from the LSB is reversed in
//              place; a short MSB group is reversed within its own width)
//         11 = reserved, treated as full reverse
//      out_q_val follows in_val one cycle later. While in_val is low, out_q
//      holds its value. There is no backpressure.
//
// Parameters:
//   nbits      data width in bits, 1..64
//
// Ports:
//   clk        clock; all registers update on the rising edge
//   reset      asynchronous, active-high; clears out_q and out_q_val
//   in_        data to reverse
//   out        combinational full reversal of in_
//   in_val     qualifies in_ for the registered path
//   rev_mode   transform select for the registered path
//   out_q      registered transformed data
//   out_q_val  registered valid for out_q
//   out_q_par  (only with PARAM_BIT_REV_PARITY_EN) XOR-reduction of out_q,
//              registered alongside it
//
// Optional feature macro: PARAM_BIT_REV_PARITY_EN
// ---------------------------------------------------------------------------
module param_bit_rev_unit #(
   parameter int nbits = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [nbits-1:0] in_,
   output logic [nbits-1:0] out,
   input  logic             in_val,
   input  logic [1:0]       rev_mode,
   output logic [nbits-1:0] out_q,
   output logic             out_q_val
`ifdef PARAM_BIT_REV_PARITY_EN
   ,
   output logic             out_q_par
`endif
);

   logic [nbits-1:0] full_rev;
   logic [nbits-1:0] nib_rev;
   logic [nbits-1:0] xform;

   // Both reversals are pure wiring. Every source index is resolved at
   // elaboration time. For nibble mode, each bit first finds the base of
   // its 4-bit group and the group's real width. The width is less than 4
   // only for the top group when nbits is not a multiple of 4. The bit then
   // mirrors its position inside that group.
   for (genvar i = 0; i < nbits; i++) begin : g_rev
      localparam int GBase = (i / 4) * 4;
      localparam int GWidth = ((nbits - GBase) < 4) ? (nbits - GBase) : 4;
      localparam int NibSrc = GBase + GWidth - 1 - (i - GBase);
      assign full_rev[i] = in_[nbits-1-i];
      assign nib_rev[i]  = in_[NibSrc];
   end

   assign out = full_rev;

   // Select the registered-path transform. The reserved mode 11 falls into
   // the default branch, so it behaves as full reverse.
   always_comb begin
      xform = full_rev;
      case (rev_mode)
         2'b01:   xform = in_;
         2'b10:   xform = nib_rev;
         default: xform = full_rev;
      endcase
   end

   // Output register. Valid follows in_val on every edge. Data is loaded
   // only on valid cycles, so a gap holds the last result. Reset clears
   // both immediately, which drops anything that was about to be captured.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_q     <= '0;
         out_q_val <= 1'b0;
      end else begin
         out_q_val <= in_val;
         if (in_val) begin
            out_q <= xform;
         end
      end
   end

`ifdef PARAM_BIT_REV_PARITY_EN
   // Parity is taken from the value being loaded, not from the old out_q,
   // so it always matches the data it sits next to.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_q_par <= 1'b0;
      end else if (in_val) begin
         out_q_par <= ^xform;
      end
   end
`endif

endmodule

// File: tb/tb_param_bit_rev_unit.sv
// ---------------------------------------------------------------------------
// tb_param_bit_rev_unit
//
// Bench for param_bit_rev_unit. Two instances are exercised side by side,
// one with nbits=8 and one with nbits=13.
//
// The combinational output is compared against a reference reversal. For
// the registered path, the expected result for each edge is pushed to a
// queue when the stimulus is driven. It is popped and compared just after
// the rising edge.
// ---------------------------------------------------------------------------
module tb_param_bit_rev_unit;

   logic        clk;
   logic        reset;

   logic [7:0]  in8;
   logic [7:0]  out8;
   logic        in_val8;
   logic [1:0]  mode8;
   logic [7:0]  outq8;
   logic        outq_val8;

   logic [12:0] in13;
   logic [12:0] out13;
   logic        in_val13;
   logic [1:0]  mode13;
   logic [12:0] outq13;
   logic        outq_val13;

`ifdef PARAM_BIT_REV_PARITY_EN
   logic        outq_par8;
   logic        outq_par13;
`endif

   typedef struct packed {
      logic        val;
      logic        par;
      logic [12:0] data;
   } exp_t;

   exp_t        q8[$];
   exp_t        q13[$];
   logic [12:0] hold8;
   logic [12:0] hold13;

   int compared;
   int mismatched;

   param_bit_rev_unit #(.nbits(8)) dut8 (
      .clk       (clk),
      .reset     (reset),
      .in_       (in8),
      .out       (out8),
      .in_val    (in_val8),
      .rev_mode  (mode8),
      .out_q     (outq8),
      .out_q_val (outq_val8)
`ifdef PARAM_BIT_REV_PARITY_EN
      ,
      .out_q_par (outq_par8)
`endif
   );

   param_bit_rev_unit #(.nbits(13)) dut13 (
      .clk       (clk),
      .reset     (reset),
      .in_       (in13),
      .out       (out13),
      .in_val    (in_val13),
      .rev_mode  (mode13),
      .out_q     (outq13),
      .out_q_val (outq_val13)
`ifdef PARAM_BIT_REV_PARITY_EN
      ,
      .out_q_par (outq_par13)
`endif
   );

   // 10-unit clock period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference transform. It walks the groups directly instead of computing
   // each bit's source index.
   function automatic logic [63:0] ref_xform(input logic [63:0] d, input int n,
                                              input logic [1:0] mode);
      logic [63:0] r;
      int w;
      r = '0;
      if (mode == 2'b01) begin
         r = d;
      end else if (mode == 2'b10) begin
         for (int base = 0; base < n; base += 4) begin
            w = (n - base < 4) ? (n - base) : 4;
            for (int k = 0; k < w; k++) r[base+k] = d[base+w-1-k];
         end
      end else begin
         for (int i = 0; i < n; i++) r[i] = d[n-1-i];
      end
      return r;
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Drive one cycle of registered-path stimulus on both instances. The
   // expected results are queued, then popped and checked after the edge.
   task automatic applyStimulus(input logic v8, input logic [1:0] m8, input logic [7:0] d8,
                                input logic v13, input logic [1:0] m13, input logic [12:0] d13);
      exp_t        e;
      logic [63:0] t;
      @(negedge clk);
      in_val8  = v8;
      mode8    = m8;
      in8      = d8;
      in_val13 = v13;
      mode13   = m13;
      in13     = d13;
      if (v8) begin
         t = ref_xform({56'd0, d8}, 8, m8);
         hold8 = t[12:0];
      end
      if (v13) begin
         t = ref_xform({51'd0, d13}, 13, m13);
         hold13 = t[12:0];
      end
      e.val = v8;  e.data = hold8;  e.par = ^hold8;  q8.push_back(e);
      e.val = v13; e.data = hold13; e.par = ^hold13; q13.push_back(e);
      @(posedge clk);
      #1;
      e = q8.pop_front();
      checkOutput("outq8", {56'd0, outq8}, {51'd0, e.data});
      checkOutput("outq_val8", {63'd0, outq_val8}, {63'd0, e.val});
`ifdef PARAM_BIT_REV_PARITY_EN
      checkOutput("outq_par8", {63'd0, outq_par8}, {63'd0, e.par});
`endif
      e = q13.pop_front();
      checkOutput("outq13", {51'd0, outq13}, {51'd0, e.data});
      checkOutput("outq_val13", {63'd0, outq_val13}, {63'd0, e.val});
`ifdef PARAM_BIT_REV_PARITY_EN
      checkOutput("outq_par13", {63'd0, outq_par13}, {63'd0, e.par});
`endif
   endtask

   initial begin
      logic [7:0]  comb8_in  [6] = '{8'h00, 8'h01, 8'h02, 8'h22, 8'h88, 8'hFF};
      logic [7:0]  comb8_exp [6] = '{8'h00, 8'h80, 8'h40, 8'h44, 8'h11, 8'hFF};
      logic [12:0] comb13_in [5] = '{13'h0001, 13'h0011, 13'h1555, 13'h0AAA, 13'h1FFF};
      logic [12:0] comb13_exp[5] = '{13'h1000, 13'h1100, 13'h1555, 13'h0AAA, 13'h1FFF};
      logic [63:0] t;

      compared   = 0;
      mismatched = 0;
      hold8      = '0;
      hold13     = '0;
      reset      = 1'b1;
      in8        = '0;
      in_val8    = 1'b0;
      mode8      = 2'b00;
      in13       = '0;
      in_val13   = 1'b0;
      mode13     = 2'b00;

      // Reset takes effect before any clock edge.
      #1;
      checkOutput("reset_outq8", {56'd0, outq8}, 64'd0);
      checkOutput("reset_outq_val8", {63'd0, outq_val8}, 64'd0);
      checkOutput("reset_outq13", {51'd0, outq13}, 64'd0);
      checkOutput("reset_outq_val13", {63'd0, outq_val13}, 64'd0);
      @(negedge clk);
      reset = 1'b0;

      // Directed combinational vectors.
      for (int i = 0; i < 6; i++) begin
         in8 = comb8_in[i];
         #8;
         checkOutput("comb8", {56'd0, out8}, {56'd0, comb8_exp[i]});
      end
      for (int i = 0; i < 5; i++) begin
         in13 = comb13_in[i];
         #8;
         checkOutput("comb13", {51'd0, out13}, {51'd0, comb13_exp[i]});
      end

      // Random combinational vectors, 20 per width.
      for (int i = 0; i < 20; i++) begin
         in8  = 8'($urandom);
         in13 = 13'($urandom);
         #8;
         t = ref_xform({56'd0, in8}, 8, 2'b00);
         checkOutput("rand_comb8", {56'd0, out8}, t);
         t = ref_xform({51'd0, in13}, 13, 2'b00);
         checkOutput("rand_comb13", {51'd0, out13}, t);
      end

      // Registered path, directed steps.
      applyStimulus(1'b1, 2'b00, 8'h01, 1'b1, 2'b10, 13'h1001);
      checkOutput("dir_outq8_full", {56'd0, outq8}, 64'h80);
      checkOutput("dir_outq13_nib", {51'd0, outq13}, 64'h1008);
      applyStimulus(1'b1, 2'b10, 8'h12, 1'b1, 2'b11, 13'h0001);
      checkOutput("dir_outq8_nib", {56'd0, outq8}, 64'h84);

      // Assert reset between edges. The registered outputs clear at once,
      // and the combinational output keeps tracking in_.
      #3;
      reset = 1'b1;
      #1;
      checkOutput("midreset_outq8", {56'd0, outq8}, 64'd0);
      checkOutput("midreset_outq_val8", {63'd0, outq_val8}, 64'd0);
      checkOutput("midreset_outq13", {51'd0, outq13}, 64'd0);
      in8 = 8'h0B;
      #1;
      checkOutput("reset_comb8", {56'd0, out8}, 64'hD0);
      @(negedge clk);
      reset  = 1'b0;
      hold8  = '0;
      hold13 = '0;

      applyStimulus(1'b1, 2'b01, 8'h12, 1'b1, 2'b01, 13'h0ABC);
      checkOutput("dir_outq8_pass", {56'd0, outq8}, 64'h12);
      applyStimulus(1'b0, 2'b00, 8'hFF, 1'b0, 2'b00, 13'h1FFF);
      checkOutput("dir_outq8_hold", {56'd0, outq8}, 64'h12);
      checkOutput("dir_outq_val8_low", {63'd0, outq_val8}, 64'd0);

`ifdef PARAM_BIT_REV_PARITY_EN
      applyStimulus(1'b1, 2'b00, 8'h07, 1'b0, 2'b00, 13'h0000);
      checkOutput("par_outq8", {56'd0, outq8}, 64'hE0);
      checkOutput("par_bit8", {63'd0, outq_par8}, 64'd1);
`endif

      // Random registered traffic, covering all modes and gaps in valid.
      for (int i = 0; i < 24; i++) begin
         applyStimulus(1'($urandom), 2'($urandom), 8'($urandom),
                       1'($urandom), 2'($urandom), 13'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
